// File: rtl/alu_md_pkg.sv
// Shared types for the alu_md execute-stage ALU: op codes, FSM states and
// op-class helpers used by the top level and the multiply/divide unit.
package alu_md_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_SLT   = 5'd2,
    OP_SLTU  = 5'd3,
    OP_AND   = 5'd4,
    OP_NOR   = 5'd5,
    OP_OR    = 5'd6,
    OP_XOR   = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_LUI   = 5'd11,
    OP_MULT  = 5'd12,
    OP_MULTU = 5'd13,
    OP_DIV   = 5'd14,
    OP_DIVU  = 5'd15,
    OP_MFHI  = 5'd16,
    OP_MFLO  = 5'd17,
    OP_MTHI  = 5'd18,
    OP_MTLO  = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIN
  } state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_md(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider working on magnitudes.
// The final iteration and the sign fix are combinational into res_hi/res_lo.
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              is_signed,
`ifdef ALU_MD_DIV_EN
  input  logic              div_sel,
`endif
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic                neg_prod_q, neg_prod_d;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   step_hi, step_lo;
  logic [2*DATA_W-1:0] prod;
`ifdef ALU_MD_DIV_EN
  logic                div_mode_q, div_mode_d;
  logic                div0_q, div0_d;
  logic                neg_a_q, neg_a_d;
  logic [DATA_W-1:0]   src1_q, src1_d;
  logic [DATA_W:0]     div_shift, div_diff;
  logic                div_ge;
`endif

  assign a_mag = (is_signed && a[DATA_W-1]) ? -a : a;
  assign b_mag = (is_signed && b[DATA_W-1]) ? -b : b;
  // Load happens on the accept edge, so DATA_W-1 registered steps plus the
  // combinational one in FIN make up the full DATA_W iterations.
  assign done  = (cnt_q == CNT_W'(DATA_W - 2));

  assign mul_sum = {1'b0, acc_hi_q} + ({1'b0, m_q} & {(DATA_W+1){acc_lo_q[0]}});
`ifdef ALU_MD_DIV_EN
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_ge    = ~div_diff[DATA_W];
`endif

  always_comb begin
    step_hi = mul_sum[DATA_W:1];
    step_lo = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
`ifdef ALU_MD_DIV_EN
    if (div_mode_q) begin
      step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      step_lo = {acc_lo_q[DATA_W-2:0], div_ge};
    end
`endif
  end

  always_comb begin
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    m_d        = m_q;
    neg_prod_d = neg_prod_q;
`ifdef ALU_MD_DIV_EN
    div_mode_d = div_mode_q;
    div0_d     = div0_q;
    neg_a_d    = neg_a_q;
    src1_d     = src1_q;
`endif
    if (start) begin
      cnt_d      = '0;
      acc_hi_d   = '0;
      acc_lo_d   = a_mag;
      m_d        = b_mag;
      neg_prod_d = is_signed & (a[DATA_W-1] ^ b[DATA_W-1]);
`ifdef ALU_MD_DIV_EN
      div_mode_d = div_sel;
      div0_d     = (b == '0);
      neg_a_d    = is_signed & a[DATA_W-1];
      src1_d     = a;
`endif
    end else if (step) begin
      cnt_d    = cnt_q + CNT_W'(1);
      acc_hi_d = step_hi;
      acc_lo_d = step_lo;
    end
  end

  always_comb begin
    prod             = {step_hi, step_lo};
    {res_hi, res_lo} = neg_prod_q ? -prod : prod;
`ifdef ALU_MD_DIV_EN
    if (div_mode_q) begin
      if (div0_q) begin
        res_lo = '1;
        res_hi = src1_q;
      end else begin
        res_lo = neg_prod_q ? -step_lo : step_lo;
        res_hi = neg_a_q ? -step_hi : step_hi;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      m_q        <= '0;
      neg_prod_q <= 1'b0;
`ifdef ALU_MD_DIV_EN
      div_mode_q <= 1'b0;
      div0_q     <= 1'b0;
      neg_a_q    <= 1'b0;
      src1_q     <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      m_q        <= m_d;
      neg_prod_q <= neg_prod_d;
`ifdef ALU_MD_DIV_EN
      div_mode_q <= div_mode_d;
      div0_q     <= div0_d;
      neg_a_q    <= neg_a_d;
      src1_q     <= src1_d;
`endif
    end
  end

endmodule

// File: rtl/alu_md.sv
// Handshaked execute-stage ALU with registered result and iterative mul/div
// feeding HI/LO. Divider is only built when ALU_MD_DIV_EN is defined.
module alu_md
  import alu_md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                accept, start_mul, start_div;
  logic                md_step, md_done;
  logic [DATA_W-1:0]   md_res_hi, md_res_lo;
  logic [DATA_W-1:0]   alu_res;
  logic [SHAMT_W-1:0]  shamt;

  assign in_ready  = !rst && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign start_mul = accept && is_mul(op);
`ifdef ALU_MD_DIV_EN
  assign start_div = accept && is_div(op);
`else
  assign start_div = 1'b0;
`endif
  assign md_step   = (state_q == S_MUL) || (state_q == S_DIV);
  assign shamt     = src1[SHAMT_W-1:0];

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start_mul || start_div),
    .step      (md_step),
    .is_signed (is_signed_md(op)),
`ifdef ALU_MD_DIV_EN
    .div_sel   (is_div(op)),
`endif
    .a         (src1),
    .b         (src2),
    .done      (md_done),
    .res_hi    (md_res_hi),
    .res_lo    (md_res_lo)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, src1 < src2};
      OP_AND:  alu_res = src1 & src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLL:  alu_res = src2 << shamt;
      OP_SRL:  alu_res = src2 >> shamt;
      OP_SRA:  alu_res = $signed(src2) >>> shamt;
      OP_LUI:  alu_res = {src2[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_mul) begin
          state_d = S_MUL;
        end else if (start_div) begin
          state_d = S_DIV;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
          if (op == OP_MTHI) hi_d = src1;
          if (op == OP_MTLO) lo_d = src1;
        end
      end
      S_MUL, S_DIV: begin
        if (md_done) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d        = md_res_hi;
        lo_d        = md_res_lo;
        out_valid_d = 1'b1;
        result_d    = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (DATA_W=32): directed vectors pinned by hand
// values, a plain-arithmetic reference model and a per-transaction checker.
module tb_alu_md;
  import alu_md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [4:0]   op = '0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result, hi, lo;

  always #5 clk = ~clk;

  alu_md #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] res, hi, lo;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, res, hi, lo;
    bit          chk_hl;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t        last;
  bit          last_multi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Reference behaviour from the architectural definition of each op.
  function automatic void model_op(input logic [4:0] o, input logic [31:0] a, b, hin, lin,
                                   output logic [31:0] res, hout, lout, output bit multi);
    logic [63:0] p;
`ifdef ALU_MD_DIV_EN
    int sa, sb;
`endif
    res = '0; hout = hin; lout = lin; multi = 1'b0; p = '0;
    case (o)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      OP_AND:  res = a & b;
      OP_NOR:  res = ~(a | b);
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = b << a[4:0];
      OP_SRL:  res = b >> a[4:0];
      OP_SRA:  res = $signed(b) >>> a[4:0];
      OP_LUI:  res = {b[15:0], 16'h0000};
      OP_MULT: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hout = p[63:32]; lout = p[31:0]; multi = 1'b1;
      end
      OP_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        hout = p[63:32]; lout = p[31:0]; multi = 1'b1;
      end
`ifdef ALU_MD_DIV_EN
      OP_DIV: begin
        multi = 1'b1;
        if (b == 32'h0) begin lout = 32'hFFFF_FFFF; hout = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lout = a; hout = 32'h0; end
        else begin sa = $signed(a); sb = $signed(b); lout = sa / sb; hout = sa % sb; end
      end
      OP_DIVU: begin
        multi = 1'b1;
        if (b == 32'h0) begin lout = 32'hFFFF_FFFF; hout = a; end
        else begin lout = a / b; hout = a % b; end
      end
`endif
      OP_MFHI: res = hin;
      OP_MFLO: res = lin;
      OP_MTHI: hout = a;
      OP_MTLO: lout = a;
      default: res = '0;
    endcase
  endfunction

  function automatic void add(input logic [4:0] o, input logic [31:0] a, b, r, h, l, input bit c);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = r; v.hi = h; v.lo = l; v.chk_hl = c;
    vecs.push_back(v);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, b, output int waited);
    bit multi;
    op = o; src1 = a; src2 = b; in_valid = 1'b1; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    model_op(o, a, b, m_hi, m_lo, last.res, last.hi, last.lo, multi);
    last.op = o; last_multi = multi;
    m_hi = last.hi; m_lo = last.lo;
    exp_q.push_back(last);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w, n;
    bit win_ok;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("txn op=%0d result=%h hi=%h lo=%h (model %h %h %h)",
                     e.op, result, hi, lo, e.res, e.hi, e.lo);
            chk("txn_result", result, e.res);
            chk("txn_hi", hi, e.hi);
            chk("txn_lo", lo, e.lo);
          end
        end
      end
      begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Multiply latency and stall window
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, w);
    n = 0; win_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
      if (!busy || in_ready) win_ok = 1'b0;
    end
    chk("mult_latency", 32'(n), 32'd33);
    chk("mult_stall_window", 32'(win_ok), 32'd1);
    @(posedge clk); #1;
    drain();

    // Directed vectors with hand-computed values
    add(OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0, 0, 0);
    add(OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 0, 0, 0);
    add(OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         0, 0, 0);
    add(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 0, 0);
    add(OP_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 0, 0);
    add(OP_NOR,  32'h0F0F_0F0F, 32'h1000_0000, 32'hE0F0_F0F0, 0, 0, 0);
    add(OP_OR,   32'h0000_00F0, 32'h0000_0F00, 32'h0000_0FF0, 0, 0, 0);
    add(OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 0, 0, 0);
    add(OP_SLL,  32'd4,         32'd1,         32'h0000_0010, 0, 0, 0);
    add(OP_SRL,  32'd4,         32'h8000_0000, 32'h0800_0000, 0, 0, 0);
    add(OP_SRA,  32'd4,         32'h8000_0000, 32'hF800_0000, 0, 0, 0);
    add(OP_SRA,  32'd35,        32'h7FFF_FFF0, 32'h0FFF_FFFE, 0, 0, 0);
    add(OP_LUI,  32'd0,         32'hFFFF_1234, 32'h1234_0000, 0, 0, 0);
    add(OP_MTHI, 32'd5,         32'd0,         32'd0,         0, 0, 0);
    add(OP_MTLO, 32'd9,         32'd0,         32'd0,         32'd5, 32'd9, 1);
    add(OP_MFHI, 32'd0,         32'd0,         32'd5,         0, 0, 0);
    add(OP_MFLO, 32'd0,         32'd0,         32'd9,         0, 0, 0);
    add(OP_MULT, 32'hFFFF_FFFD, 32'd7,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
    add(OP_MULTU,32'hFFFF_FFFF, 32'd2,         32'd0, 32'd1, 32'hFFFF_FFFE, 1);
    add(OP_MULT, 32'd6,         32'd7,         32'd0, 32'd0, 32'd42, 1);
    add(OP_MFLO, 32'd0,         32'd0,         32'd42,        0, 0, 0);
    add(5'd25,   32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 32'd42, 1);
`ifdef ALU_MD_DIV_EN
    add(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
    add(OP_DIVU, 32'd7,         32'd0,         32'd0, 32'd7, 32'hFFFF_FFFF, 1);
    add(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 1);
    add(OP_DIV,  32'hFFFF_FFF9, 32'd0,         32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    add(OP_DIVU, 32'd100,       32'd7,         32'd0, 32'd2, 32'd14, 1);
    add(OP_MFHI, 32'd0,         32'd0,         32'd2,         0, 0, 0);
`else
    add(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'd0, 32'd0, 32'd42, 1);
    add(OP_DIVU, 32'd7,         32'd0,         32'd0, 32'd0, 32'd42, 1);
    add(OP_MFLO, 32'd0,         32'd0,         32'd42,        0, 0, 0);
`endif
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, w);
      chk($sformatf("pin%0d_res", i), last.res, vecs[i].res);
      if (vecs[i].chk_hl) begin
        chk($sformatf("pin%0d_hi", i), last.hi, vecs[i].hi);
        chk($sformatf("pin%0d_lo", i), last.lo, vecs[i].lo);
      end
    end
    drain();

    // Backpressure: result held, accept resumes on the release edge
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, w);
    win_ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || result !== 32'd3 || in_ready) win_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("backpressure_hold", 32'(win_ok), 32'd1);
    out_ready = 1'b1;
    issue(OP_XOR, 32'd5, 32'd3, w);
    chk("accept_on_release", 32'(w), 32'd0);
    drain();

    // Reset in the middle of a divide
    issue(OP_MTHI, 32'h55, 32'd0, w);
    issue(OP_DIV, 32'd100, 32'd7, w);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", 32'(busy), 32'(last_multi));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(OP_ADD, 32'd2, 32'd3, w);
    chk("post_abort_model", last.res, 32'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
